// File: rtl/r2_alu_if.sv
// r2_alu operand/result bundle.
// Master drives opcode and operands; slave returns registered results.
interface r2_alu_if;
    logic       select0;
    logic       select1;
    logic [3:0] bit1;
    logic [3:0] bit2;
    logic [4:0] result1;
    logic [4:0] result2;
    logic       equal;
    logic       greater;
    logic       lesser;
    logic [4:0] result4;

    modport master (
        output select0, select1, bit1, bit2,
        input  result1, result2, equal, greater, lesser, result4
    );

    modport slave (
        input  select0, select1, bit1, bit2,
        output result1, result2, equal, greater, lesser, result4
    );
endinterface

// File: rtl/r2_alu.sv
// Registered 4-bit ALU: add, sub, unsigned compare, and.
// Each op owns its result port; unselected ports register zero.
module r2_alu (
    input logic    clk,
    input logic    rst_n,
    r2_alu_if.slave bus
);
    logic       w_op_add;
    logic       w_op_sub;
    logic       w_op_cmp;
    logic       w_op_and;
    logic [4:0] w_a;
    logic [4:0] w_b;
    logic [4:0] w_result1;
    logic [4:0] w_result2;
    logic [4:0] w_result4;
    logic       w_equal;
    logic       w_greater;
    logic       w_lesser;

    logic [4:0] r_result1;
    logic [4:0] r_result2;
    logic [4:0] r_result4;
    logic       r_equal;
    logic       r_greater;
    logic       r_lesser;

    assign w_a      = {1'b0, bus.bit1};
    assign w_b      = {1'b0, bus.bit2};
    assign w_op_add = ~bus.select1 & ~bus.select0;
    assign w_op_sub = ~bus.select1 &  bus.select0;
    assign w_op_cmp =  bus.select1 & ~bus.select0;
    assign w_op_and =  bus.select1 &  bus.select0;

    always_comb begin
        w_result1 = 5'd0;
        w_result2 = 5'd0;
        w_result4 = 5'd0;
        w_equal   = 1'b0;
        w_greater = 1'b0;
        w_lesser  = 1'b0;
        unique case (1'b1)
            w_op_add: w_result1 = w_a + w_b;
            w_op_sub: w_result2 = w_a - w_b;
            w_op_cmp: begin
                w_equal   = (bus.bit1 == bus.bit2);
                w_greater = (bus.bit1 >  bus.bit2);
                w_lesser  = (bus.bit1 <  bus.bit2);
            end
            w_op_and: w_result4 = {1'b0, bus.bit1 & bus.bit2};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result1 <= 5'd0;
            r_result2 <= 5'd0;
            r_result4 <= 5'd0;
            r_equal   <= 1'b0;
            r_greater <= 1'b0;
            r_lesser  <= 1'b0;
        end else begin
            r_result1 <= w_result1;
            r_result2 <= w_result2;
            r_result4 <= w_result4;
            r_equal   <= w_equal;
            r_greater <= w_greater;
            r_lesser  <= w_lesser;
        end
    end

    assign bus.result1 = r_result1;
    assign bus.result2 = r_result2;
    assign bus.result4 = r_result4;
    assign bus.equal   = r_equal;
    assign bus.greater = r_greater;
    assign bus.lesser  = r_lesser;
endmodule

// File: tb/tb_r2_alu.sv
// Scoreboard bench for r2_alu: driver queues expected results,
// monitor pops and compares one cycle after each drive.
module tb_r2_alu;
    typedef struct {
        string      name;
        logic [17:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    r2_alu_if bus ();

    r2_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] pack(
        input logic [4:0] r1, input logic [4:0] r2,
        input logic [4:0] r4, input logic eq,
        input logic gt, input logic lt);
        return {r1, r2, r4, eq, gt, lt};
    endfunction

    // Independent reference using integer arithmetic.
    function automatic logic [17:0] model(
        input logic rst, input logic [1:0] op,
        input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int d;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] r4;
        logic eq;
        logic gt;
        logic lt;
        ia = int'(a);
        ib = int'(b);
        r1 = 5'd0;
        r2 = 5'd0;
        r4 = 5'd0;
        eq = 1'b0;
        gt = 1'b0;
        lt = 1'b0;
        if (rst) begin
            if (op == 2'd0) r1 = 5'((ia + ib) % 32);
            if (op == 2'd1) begin
                d  = ia - ib + 32;
                r2 = 5'(d % 32);
            end
            if (op == 2'd2) begin
                d  = ia - ib;
                eq = (d == 0);
                gt = (d > 0);
                lt = (d < 0);
            end
            if (op == 2'd3) r4 = {1'b0, a & b};
        end
        return pack(r1, r2, r4, eq, gt, lt);
    endfunction

    task automatic drive(
        input string name, input logic rst, input logic [1:0] op,
        input logic [3:0] a, input logic [3:0] b,
        input logic [17:0] expv);
        exp_t e;
        @(negedge clk);
        rst_n       = rst;
        bus.select1 = op[1];
        bus.select0 = op[0];
        bus.bit1    = a;
        bus.bit2    = b;
        e.name      = name;
        e.v         = expv;
        sb.push_back(e);
    endtask

    task automatic rnd(input string name, input logic rst,
                       input logic [1:0] op);
        logic [3:0] a;
        logic [3:0] b;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        drive(name, rst, op, a, b, model(rst, op, a, b));
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic [17:0] got;
        #1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {bus.result1, bus.result2, bus.result4,
                   bus.equal, bus.greater, bus.lesser};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got r1=%b r2=%b r4=%b eq/gt/lt=%b expected r1=%b r2=%b r4=%b eq/gt/lt=%b",
                         e.name, got[17:13], got[12:8], got[7:3], got[2:0],
                         e.v[17:13], e.v[12:8], e.v[7:3], e.v[2:0]);
            end
        end
    end

    initial begin
        logic [17:0] z;
        logic        r;
        int          wait_cyc;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.select0 = 1'b0;
        bus.select1 = 1'b0;
        bus.bit1    = 4'd0;
        bus.bit2    = 4'd0;
        z = 18'd0;

        drive("rst0", 1'b0, 2'b11, 4'b1111, 4'b1111, z);
        drive("rst1", 1'b0, 2'b11, 4'b1111, 4'b1111, z);
        drive("rel_and", 1'b1, 2'b11, 4'b1111, 4'b1111,
              pack(5'd0, 5'd0, 5'b01111, 1'b0, 1'b0, 1'b0));

        drive("add_carry", 1'b1, 2'b00, 4'b0110, 4'b1100,
              pack(5'b10010, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        drive("add_max", 1'b1, 2'b00, 4'b1111, 4'b1111,
              pack(5'b11110, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));

        drive("sub_pos", 1'b1, 2'b01, 4'b1010, 4'b0010,
              pack(5'd0, 5'b01000, 5'd0, 1'b0, 1'b0, 1'b0));
        drive("sub_neg", 1'b1, 2'b01, 4'b0010, 4'b1010,
              pack(5'd0, 5'b11000, 5'd0, 1'b0, 1'b0, 1'b0));
        drive("sub_zero", 1'b1, 2'b01, 4'b0101, 4'b0101,
              pack(5'd0, 5'b00000, 5'd0, 1'b0, 1'b0, 1'b0));
        drive("sub_min", 1'b1, 2'b01, 4'b0000, 4'b1111,
              pack(5'd0, 5'b10001, 5'd0, 1'b0, 1'b0, 1'b0));

        drive("cmp_lt", 1'b1, 2'b10, 4'b1011, 4'b1111,
              pack(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        drive("cmp_gt", 1'b1, 2'b10, 4'b1111, 4'b1011,
              pack(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        drive("cmp_eq", 1'b1, 2'b10, 4'b0111, 4'b0111,
              pack(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0));

        drive("and_zero", 1'b1, 2'b11, 4'b1111, 4'b0000,
              pack(5'd0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0));
        drive("and_mix", 1'b1, 2'b11, 4'b1101, 4'b0111,
              pack(5'd0, 5'd0, 5'b00101, 1'b0, 1'b0, 1'b0));

        drive("midrst", 1'b0, 2'b00, 4'b1111, 4'b0001, z);
        drive("post_rst", 1'b1, 2'b00, 4'b0001, 4'b0010,
              pack(5'b00011, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 12; i++)
            rnd("b2b", 1'b1, 2'(i % 4));

        for (int i = 0; i < 1000; i++) begin
            r = ($urandom_range(0, 19) != 0);
            rnd("rand", r, 2'($urandom_range(0, 3)));
        end

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
